// File: rtl/ifu_fetch_if.sv
// ============================================================================
// Module      : ifu_fetch_if
// Description : Bundles the instruction-memory request/response channel, the
//               decode valid/ready channel and the redirect input of the
//               fetch stage.
//               master : fetch stage side (drives requests and instructions)
//               slave  : environment side (memory, decode, execute/CSR)
// Ports       : none; signals only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifu_fetch_if;
    // Instruction memory request
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    // Instruction memory response
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    // Decode handshake
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    // PC override from execute/CSR
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc
    );
endinterface

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module      : ifu_fetch
// Description : Multi-cycle instruction fetch stage. Holds the architectural
//               PC, issues one word request at a time, buffers the returned
//               word and hands it to decode with valid/ready. Redirects
//               squash any in-flight fetch.
// Ports       : clk         - clock, rising edge
//               rst         - synchronous active-high reset
//               bus         - ifu_fetch_if.master (imem req/rsp, decode, redirect)
//               fetch_cnt_o - count of instructions delivered to decode
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          CNT_W    = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    ifu_fetch_if.master           bus,
    output logic [CNT_W-1:0]      fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       inst_pc_q, inst_pc_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_hs;
    logic              dec_hs;
    logic              inst_valid;
    logic [31:0]       redirect_tgt;

    assign inst_valid   = (state_q == S_HOLD) && !drop_q;
    assign req_hs       = (state_q == S_REQ) && bus.imem_req_ready;
    assign dec_hs       = inst_valid && bus.inst_ready;
    // Low two bits of the redirect target are discarded on load.
    assign redirect_tgt = bus.redirect_pc & ALIGN_MASK;

    assign bus.imem_req_valid = (state_q == S_REQ);
    assign bus.imem_req_addr  = pc_q & ALIGN_MASK;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign fetch_cnt_o        = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC & ALIGN_MASK;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            drop_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        drop_d    = drop_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            S_REQ: begin
                if (bus.redirect_valid) begin
                    pc_d = redirect_tgt;
                    // A request accepted this cycle still carries the old PC,
                    // so its response must be thrown away.
                    if (req_hs) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (req_hs) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (bus.imem_rsp_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (bus.imem_rsp_valid) begin
                    if (drop_q) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        inst_d    = bus.imem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // A redirect pre-empts the decode handshake: the instruction
                // is not counted and the PC does not step past it.
                if (bus.redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (dec_hs) begin
                    pc_d    = pc_q + 32'd4;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Directed self-checking bench for ifu_fetch. Inputs change 1ns
//               after each rising edge and outputs are checked at that point.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_cnt;
    int          errors;
    int          checks;

    ifu_fetch_if bus ();

    ifu_fetch #(
        .RESET_PC (32'h8000_0000),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .fetch_cnt_o (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;

        // ---- Reset state ----
        chk("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        chk("rst_addr",      bus.imem_req_addr,           32'h8000_0000);
        chk("rst_inst_valid",{31'h0, bus.inst_valid},     32'h0);
        chk("rst_inst",      bus.inst,                    32'h0);
        chk("rst_inst_pc",   bus.inst_pc,                 32'h0);
        chk("rst_cnt",       fetch_cnt,                   32'h0);

        // ---- Memory not ready for 3 cycles: request held ----
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
            chk("stall_addr",      bus.imem_req_addr,           32'h8000_0000);
        end

        // ---- Basic fetch, 1-cycle response latency ----
        bus.imem_req_ready = 1'b1;
        step();                                   // accepted -> WAIT
        bus.imem_req_ready = 1'b0;
        chk("wait_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        chk("wait_inst_valid",{31'h0, bus.inst_valid},     32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0413;
        step();                                   // -> HOLD
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        chk("f1_inst_valid", {31'h0, bus.inst_valid}, 32'h1);
        chk("f1_inst",       bus.inst,                32'h0000_0413);
        chk("f1_inst_pc",    bus.inst_pc,             32'h8000_0000);

        // ---- Decode backpressure for 5 cycles ----
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_inst_valid", {31'h0, bus.inst_valid},     32'h1);
            chk("bp_inst",       bus.inst,                    32'h0000_0413);
            chk("bp_inst_pc",    bus.inst_pc,                 32'h8000_0000);
            chk("bp_req_valid",  {31'h0, bus.imem_req_valid}, 32'h0);
            chk("bp_cnt",        fetch_cnt,                   32'h0);
        end
        bus.inst_ready = 1'b1;
        step();                                   // handshake -> REQ
        bus.inst_ready = 1'b0;
        chk("hs_inst_valid", {31'h0, bus.inst_valid},     32'h0);
        chk("hs_req_valid",  {31'h0, bus.imem_req_valid}, 32'h1);
        chk("hs_addr",       bus.imem_req_addr,           32'h8000_0004);
        chk("hs_cnt",        fetch_cnt,                   32'h1);
        step();
        chk("hs_once_cnt",   fetch_cnt,                   32'h1);

        // ---- Redirect while waiting: in-flight response dropped ----
        bus.imem_req_ready = 1'b1;
        step();                                   // accepted -> WAIT
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0103;
        step();                                   // WAIT, drop set
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        chk("rw_inst_valid", {31'h0, bus.inst_valid},     32'h0);
        chk("rw_req_valid",  {31'h0, bus.imem_req_valid}, 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        step();                                   // response discarded -> REQ
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        chk("rw_drop_valid", {31'h0, bus.inst_valid},     32'h0);
        chk("rw_req_again",  {31'h0, bus.imem_req_valid}, 32'h1);
        chk("rw_addr",       bus.imem_req_addr,           32'h8000_0100);
        chk("rw_cnt",        fetch_cnt,                   32'h1);

        // ---- Redirect in HOLD with same-cycle decode handshake ----
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h1111_1111;
        step();                                   // -> HOLD
        bus.imem_rsp_valid = 1'b0;
        chk("rh_inst",       bus.inst,                32'h1111_1111);
        chk("rh_inst_pc",    bus.inst_pc,             32'h8000_0100);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        step();
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("rh_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("rh_cnt",        fetch_cnt,               32'h1);
        chk("rh_addr",       bus.imem_req_addr,       32'h8000_0200);

        // ---- Redirect in REQ coinciding with request acceptance ----
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0300;
        step();                                   // WAIT with drop
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h2222_2222;
        step();                                   // discarded -> REQ
        bus.imem_rsp_valid = 1'b0;
        chk("rq_inst_valid", {31'h0, bus.inst_valid},     32'h0);
        chk("rq_req_valid",  {31'h0, bus.imem_req_valid}, 32'h1);
        chk("rq_addr",       bus.imem_req_addr,           32'h8000_0300);

        // ---- PC wrap at top of address space ----
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        chk("wr_addr_top",   bus.imem_req_addr,           32'hFFFF_FFFC);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h3333_3333;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("wr_inst_pc",    bus.inst_pc,                 32'hFFFF_FFFC);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk("wr_addr_zero",  bus.imem_req_addr,           32'h0000_0000);
        chk("wr_cnt",        fetch_cnt,                   32'h2);

        // ---- Reset during WAIT, then a stray response ----
        bus.imem_req_ready = 1'b1;
        step();                                   // -> WAIT
        bus.imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_req_valid",  {31'h0, bus.imem_req_valid}, 32'h1);
        chk("rr_addr",       bus.imem_req_addr,           32'h8000_0000);
        chk("rr_inst",       bus.inst,                    32'h0);
        chk("rr_inst_pc",    bus.inst_pc,                 32'h0);
        chk("rr_cnt",        fetch_cnt,                   32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hCAFE_BABE;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("rr_stray_valid",{31'h0, bus.inst_valid},     32'h0);
        chk("rr_stray_req",  {31'h0, bus.imem_req_valid}, 32'h1);
        chk("rr_stray_inst", bus.inst,                    32'h0);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0013;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("rr_f_inst",     bus.inst,                    32'h0000_0013);
        chk("rr_f_inst_pc",  bus.inst_pc,                 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Multi-cycle instruction fetch stage that replaces the combinational fetch path in front of decode.
- Holds the architectural PC and issues one word request at a time to the instruction memory port.
- Buffers the returned word and presents it to decode with a valid/ready handshake.
- Accepts PC redirects from execute/CSR (branch, jump, trap) and squashes any in-flight fetch.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
CNT_W, 32, width of the delivered-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response data valid, one pulse per accepted request
imem_rsp_data  in  32  fetched instruction word
inst_valid  out  1  buffered instruction available to decode
inst_ready  in  1  decode consumes instruction
inst  out  32  buffered instruction
inst_pc  out  32  PC of buffered instruction
redirect_valid  in  1  next PC override (taken branch/jump/trap/mret)
redirect_pc  in  32  override target
fetch_cnt  out  CNT_W  instructions delivered to decode

Behaviour:
- States: REQ (imem_req_valid=1), WAIT (request accepted, awaiting response), HOLD (inst_valid=1).
- Reset: state=REQ, pc=RESET_PC, inst=0, inst_pc=0, drop=0, fetch_cnt=0, inst_valid=0. imem_req_valid=1 in the first cycle after rst deasserts.
- imem_req_addr = {pc[31:2],2'b00} always. redirect_pc[1:0] is ignored (cleared on load).
- REQ: on imem_req_valid&imem_req_ready, go to WAIT.
- WAIT: on imem_rsp_valid, capture data into inst, capture pc into inst_pc, and go to HOLD. Minimum latency is request accept to inst_valid = 1 cycle after rsp_valid.
- HOLD: inst/inst_pc stay stable while inst_valid&!inst_ready. On handshake: pc<=pc+4, fetch_cnt++, go to REQ.
- Redirect (any state) sets pc<=redirect_pc. Redirect has priority over every other event in the same cycle.
  - REQ, no request handshake: next request uses the new pc; stays in REQ.
  - REQ, request handshake in the same cycle: go to WAIT with drop=1.
  - WAIT: drop<=1. On the next rsp_valid, discard data, clear drop, go to REQ.
  - WAIT with rsp_valid in the same cycle as redirect: discard the response, go to REQ.
  - HOLD: inst_valid drops next cycle; the decode handshake in that cycle does not count and does not advance pc; go to REQ.
- inst_valid=1 only in HOLD with drop=0. Dropped responses are never presented to decode.
- Responses with no outstanding request are ignored.
- pc+4 wraps 32'hFFFF_FFFC -> 0. fetch_cnt wraps modulo 2^CNT_W.
- rst asserted in any state (mid-request, mid-wait): immediate return to reset values next edge. Any later stray response is ignored because state is REQ.
- At most one outstanding request. imem_req_valid=0 outside REQ.

Test Plan:
- Reset, then imem_req_ready=1 and 1-cycle response latency with data 32'h00000413: first request addr 8000_0000; inst_valid with inst=00000413, inst_pc=8000_0000; after inst_ready, next addr 8000_0004, fetch_cnt=1.
- Backpressure: hold inst_ready=0 for 5 cycles: inst/inst_pc stable, imem_req_valid=0, fetch_cnt unchanged. Then release: exactly one handshake.
- imem_req_ready=0 for 3 cycles: req_valid held high with addr stable at 8000_0000. WAIT entered only on ready.
- Redirect to 8000_0103 while in WAIT: the in-flight response (DEADBEEF) never reaches decode; next request addr 8000_0100; fetch_cnt unchanged.
- Redirect to 8000_0200 in HOLD with inst_ready=1 same cycle: no count increment, inst_valid low next cycle, next request addr 8000_0200.
- Assert rst during WAIT, then deliver a stray rsp_valid: outputs at reset values, stray response ignored, first request addr 8000_0000.
